imem_loader: RTL and testbench

Boot-time program loader and run controller for the instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each word is written into the instruction memory write port (address, data, write-enable) at consecutive addresses from 0. The processor is held stopped (`cpu_run` low) until the programmed number of words has been written, then released.

---
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Boot-time program loader. Assembles big-endian 32-bit words from
//            a byte stream and writes them to instruction memory from address
//            0 upward. The processor is released once the requested number of
//            words has been written.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic [ADDR_W-1:0] imem_a,
   output logic [31:0]       imem_d,
   output logic              imem_we,
   output logic              busy,
   output logic              done,
   output logic              cpu_run,
   output logic [ADDR_W:0]   words_loaded
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_W   = (ADDR_W + 1)'(1);

   state_t              state;
   logic [31:0]         asm_word;
   logic [1:0]          byte_cnt;
   logic [ADDR_W-1:0]   addr;
   logic [ADDR_W:0]     len_lat;
   logic [ADDR_W:0]     eff_len;
   logic                accept;
   logic [ADDR_W:0]     next_count;

   // Clamp the requested length so the write address can never wrap.
   always_comb begin
      eff_len    = (len > DEPTH_W) ? DEPTH_W : len;
      accept     = byte_valid && byte_ready;
      next_count = words_loaded + ONE_W;
   end

   // Load controller: state, handshake, word assembly and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         asm_word     <= '0;
         byte_cnt     <= '0;
         addr         <= '0;
         len_lat      <= '0;
         byte_ready   <= 1'b0;
         imem_a       <= '0;
         imem_d       <= '0;
         imem_we      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         cpu_run      <= 1'b0;
         words_loaded <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  addr         <= '0;
                  byte_cnt     <= '0;
                  asm_word     <= '0;
                  words_loaded <= '0;
                  len_lat      <= eff_len;
                  if (eff_len == '0) begin
                     state      <= S_DONE;
                     byte_ready <= 1'b0;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     cpu_run    <= 1'b1;
                  end else begin
                     state      <= S_RECV;
                     byte_ready <= 1'b1;
                     busy       <= 1'b1;
                     done       <= 1'b0;
                     cpu_run    <= 1'b0;
                  end
               end
            end
            S_RECV: begin
               if (accept) begin
                  asm_word <= {asm_word[23:0], byte_data};
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     // Word complete: present it on the memory port next cycle.
                     imem_d     <= {asm_word[23:0], byte_data};
                     imem_a     <= addr;
                     imem_we    <= 1'b1;
                     byte_ready <= 1'b0;
                     state      <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               imem_we      <= 1'b0;
               addr         <= addr + ADDR_W'(1);
               words_loaded <= next_count;
               if (next_count == len_lat) begin
                  state   <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  cpu_run <= 1'b1;
               end else begin
                  state      <= S_RECV;
                  byte_ready <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Directed self-checking bench for imem_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1024;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W:0]   len;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic [ADDR_W-1:0] imem_a;
   logic [31:0]       imem_d;
   logic              imem_we;
   logic              busy;
   logic              done;
   logic              cpu_run;
   logic [ADDR_W:0]   words_loaded;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   int t0;
   int errs;
   int zeros;

   logic [ADDR_W-1:0] wa[$];
   logic [31:0]       wd[$];

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .len          (len),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_ready   (byte_ready),
      .imem_a       (imem_a),
      .imem_d       (imem_d),
      .imem_we      (imem_we),
      .busy         (busy),
      .done         (done),
      .cpu_run      (cpu_run),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Capture every memory write; byte_ready must be low while writing.
   always @(negedge clk) begin
      if (rst === 1'b0 && imem_we === 1'b1) begin
         wa.push_back(imem_a);
         wd.push_back(imem_d);
         chk("ready_low_in_write", {63'd0, byte_ready}, 64'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (byte_ready !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      if (byte_ready !== 1'b1) chk("byte_accept_timeout", {63'd0, byte_ready}, 64'd1);
      step();
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (gap) step();
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      send_byte(w[31:24], gap);
      send_byte(w[23:16], gap);
      send_byte(w[15:8],  gap);
      send_byte(w[7:0],   gap);
   endtask

   task automatic do_start(input logic [ADDR_W:0] l);
      start = 1'b1;
      len   = l;
      step();
      start = 1'b0;
      len   = '1;
   endtask

   task automatic wait_run();
      int n;
      n = 0;
      while (cpu_run !== 1'b1 && n < 200) begin
         step();
         n++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; len = '0; byte_valid = 1'b0; byte_data = 8'h00;
      step(); step();
      chk("reset_flags", {59'd0, byte_ready, imem_we, busy, done, cpu_run}, 64'd0);
      chk("reset_regs", {imem_a, imem_d, words_loaded}, 64'd0);
      rst = 1'b0;
      step();

      // Bytes offered while idle are not consumed.
      byte_valid = 1'b1; byte_data = 8'hAA;
      step(); step(); step();
      chk("idle_ready", {63'd0, byte_ready}, 64'd0);
      byte_valid = 1'b0;

      // Two-word load, back-to-back bytes.
      wa.delete(); wd.delete();
      do_start(11'd2);
      t0 = cyc;
      chk("start_busy_ready", {62'd0, busy, byte_ready}, 64'd3);
      send_word(32'h2001000A, 0);
      send_word(32'h20220014, 0);
      wait_run();
      chk("run_latency", 64'(cyc - t0), 64'd10);
      chk("two_count", 64'(wa.size()), 64'd2);
      chk("two_w0", {22'd0, wa[0], wd[0]}, {22'd0, 10'd0, 32'h2001000A});
      chk("two_w1", {22'd0, wa[1], wd[1]}, {22'd0, 10'd1, 32'h20220014});
      chk("two_loaded", 64'(words_loaded), 64'd2);
      chk("two_done_state", {61'd0, done, busy, cpu_run}, 64'h5);
      chk("two_hold_d", 64'(imem_d), 64'h20220014);

      // Same stream with producer stalls between every byte.
      wa.delete(); wd.delete();
      do_start(11'd2);
      chk("bp_run_dropped", {63'd0, cpu_run}, 64'd0);
      send_word(32'h2001000A, 3);
      send_word(32'h20220014, 3);
      wait_run();
      chk("bp_count", 64'(wa.size()), 64'd2);
      chk("bp_w0", {22'd0, wa[0], wd[0]}, {22'd0, 10'd0, 32'h2001000A});
      chk("bp_w1", {22'd0, wa[1], wd[1]}, {22'd0, 10'd1, 32'h20220014});
      chk("bp_loaded", 64'(words_loaded), 64'd2);

      // Zero-length load completes immediately without writing.
      wa.delete(); wd.delete();
      do_start(11'd0);
      chk("len0_flags", {61'd0, done, cpu_run, busy}, 64'h6);
      chk("len0_loaded", 64'(words_loaded), 64'd0);
      repeat (5) step();
      chk("len0_no_write", 64'(wa.size()), 64'd0);

      // Reset in the middle of the second word.
      wa.delete(); wd.delete();
      do_start(11'd2);
      send_word(32'h01020304, 0);
      send_byte(8'h05, 0);
      send_byte(8'h06, 0);
      chk("mid_first_write", 64'(wa.size()), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_reset_flags", {59'd0, byte_ready, imem_we, busy, done, cpu_run}, 64'd0);
      chk("mid_reset_regs", {imem_a, imem_d, words_loaded}, 64'd0);
      step();
      rst = 1'b0;
      step();
      chk("mid_run_low", {63'd0, cpu_run}, 64'd0);
      wa.delete(); wd.delete();
      do_start(11'd1);
      send_word(32'hFC000000, 0);
      wait_run();
      chk("mid_new_count", 64'(wa.size()), 64'd1);
      chk("mid_new_w0", {22'd0, wa[0], wd[0]}, {22'd0, 10'd0, 32'hFC000000});
      chk("mid_new_loaded", 64'(words_loaded), 64'd1);

      // A start pulse during RECV is ignored.
      wa.delete(); wd.delete();
      do_start(11'd2);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      start = 1'b1; len = 11'd1;
      step();
      start = 1'b0;
      chk("ign_busy", {63'd0, busy}, 64'd1);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      send_word(32'h55667788, 0);
      wait_run();
      chk("ign_count", 64'(wa.size()), 64'd2);
      chk("ign_w0", {22'd0, wa[0], wd[0]}, {22'd0, 10'd0, 32'h11223344});
      chk("ign_w1", {22'd0, wa[1], wd[1]}, {22'd0, 10'd1, 32'h55667788});
      chk("ign_loaded", 64'(words_loaded), 64'd2);

      // Restart from DONE rewrites address 0.
      wa.delete(); wd.delete();
      do_start(11'd1);
      chk("rs_run_dropped", {62'd0, cpu_run, busy}, 64'd1);
      send_word(32'hDEADBEEF, 0);
      wait_run();
      chk("rs_count", 64'(wa.size()), 64'd1);
      chk("rs_w0", {22'd0, wa[0], wd[0]}, {22'd0, 10'd0, 32'hDEADBEEF});
      chk("rs_run", {63'd0, cpu_run}, 64'd1);

      // Oversized length is clamped to the memory depth.
      wa.delete(); wd.delete();
      do_start(11'd1100);
      for (int i = 0; i < DEPTH; i++) send_word(32'(i), 0);
      wait_run();
      chk("clamp_count", 64'(wa.size()), 64'd1024);
      chk("clamp_last", {22'd0, wa[wa.size()-1], wd[wd.size()-1]}, {22'd0, 10'd1023, 32'd1023});
      chk("clamp_loaded", 64'(words_loaded), 64'd1024);
      chk("clamp_done", {62'd0, done, cpu_run}, 64'd3);
      errs = 0;
      zeros = 0;
      for (int i = 0; i < wa.size(); i++) begin
         if (wa[i] == '0) zeros++;
         if (32'(wa[i]) != i || wd[i] != 32'(i)) errs++;
      end
      chk("clamp_seq_errors", 64'(errs), 64'd0);
      chk("clamp_addr0_writes", 64'(zeros), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
